// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from imem
// and hands {inst, pc} to decode; execute redirects squash stale fetches.
module ifu_fetch #(
    parameter int              XLEN      = 32,
    parameter int              ISA_WIDTH = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    output logic [XLEN-1:0]      imem_req_addr,
    input  logic                 imem_req_ready,
    input  logic                 imem_resp_valid,
    input  logic [ISA_WIDTH-1:0] imem_resp_data,
    input  logic                 imem_resp_err,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [ISA_WIDTH-1:0] inst,
    output logic [XLEN-1:0]      pc,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 fault,
    output logic [31:0]          fetch_cnt
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_d;
    logic [XLEN-1:0]      pc_d;
    logic [ISA_WIDTH-1:0] inst_d;
    logic                 kill;
    logic                 kill_d;
    logic [31:0]          cnt_d;
    logic                 redir_bad;

    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Request valid is masked by rst so nothing is offered while held in reset.
    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_HOLD);
    assign fault          = (state == S_ERR);

    always_comb begin
        state_d = state;
        pc_d    = pc;
        inst_d  = inst;
        kill_d  = kill;
        cnt_d   = fetch_cnt;
        unique case (state)
            S_REQ: begin
                if (redir_bad) begin
                    state_d = S_ERR;
                    pc_d    = redirect_pc;
                end else begin
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end
                    // A request accepted alongside a redirect is already stale.
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        kill_d  = redirect_valid;
                    end
                end
            end
            S_WAIT: begin
                if (redir_bad) begin
                    state_d = S_ERR;
                    pc_d    = redirect_pc;
                    kill_d  = 1'b0;
                end else if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_resp_valid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else if (imem_resp_err) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_HOLD;
                        inst_d  = imem_resp_data;
                    end
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    cnt_d = fetch_cnt + 32'd1;
                end
                if (redir_bad) begin
                    state_d = S_ERR;
                    pc_d    = redirect_pc;
                end else if (redirect_valid) begin
                    state_d = S_REQ;
                    pc_d    = redirect_pc;
                end else if (inst_ready) begin
                    state_d = S_REQ;
                    pc_d    = pc + XLEN'(4);
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            inst      <= '0;
            kill      <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            inst      <= inst_d;
            kill      <= kill_d;
            fetch_cnt <= cnt_d;
        end
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the decode unit.
- Owns the PC and issues word fetches to instruction memory over a request/response handshake.
- Presents {inst, pc} to decode with a valid/ready handshake.
- Accepts PC redirects from execute (branch/jump) and discards stale in-flight fetches.

Parameters:
- XLEN, 32, address/PC width.
- ISA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  XLEN  fetch address, always equals pc.
- imem_req_ready  input  1  memory accepts request.
- imem_resp_valid  input  1  response data valid; at most one outstanding request.
- imem_resp_data  input  ISA_WIDTH  fetched word.
- imem_resp_err  input  1  access fault, qualified by imem_resp_valid.
- inst_valid  output  1  instruction held for decode.
- inst_ready  input  1  decode accepts instruction.
- inst  output  ISA_WIDTH  held instruction word.
- pc  output  XLEN  PC of the held instruction or current fetch.
- redirect_valid  input  1  execute redirects the PC.
- redirect_pc  input  XLEN  redirect target.
- fault  output  1  sticky fetch fault.
- fetch_cnt  output  32  number of instructions delivered to decode.

Behaviour:
- Reset (async, rst=1):
  - State = REQ, pc = RESET_PC, inst = 0, kill = 0, fault = 0, fetch_cnt = 0.
  - All valids deassert immediately.
- Outputs are decoded from registered state only:
  - imem_req_valid = (state==REQ).
  - inst_valid = (state==HOLD).
  - imem_req_addr = pc.
- State REQ:
  - On imem_req_ready, go to WAIT.
  - Latency is one cycle minimum per state transition.
- State WAIT:
  - On imem_resp_valid with kill=0 and err=0: capture inst <= imem_resp_data, go to HOLD.
  - With kill=1: drop the response, clear kill, go to REQ.
  - With err=1 and kill=0: go to ERR.
  - With err=1 and kill=1: the response is dropped and does not fault.
- State HOLD:
  - inst and pc stay stable while inst_valid=1 and inst_ready=0.
  - On inst_ready: pc <= pc+4 (mod 2^XLEN, wraps), fetch_cnt += 1 (wraps), go to REQ.
  - The next request appears the cycle after the handshake.
- State ERR:
  - fault = 1; no requests issued, inst_valid = 0.
  - Exited only by rst.
- Redirect (redirect_valid=1) has priority over the sequential pc update and is sampled in REQ, WAIT and HOLD:
  - Misaligned target (redirect_pc[1:0] != 0): go to ERR, pc <= redirect_pc.
  - Otherwise pc <= redirect_pc, then by state:
    - REQ, no imem_req_ready: stay REQ.
    - REQ with imem_req_ready the same cycle: the stale request is issued; go to WAIT with kill=1.
    - WAIT, no response this cycle: kill <= 1, stay WAIT.
    - WAIT with a response the same cycle: the response is dropped; go to REQ.
    - HOLD: go to REQ. If inst_ready is also 1, the held instruction counts as delivered (fetch_cnt += 1), but pc takes redirect_pc, not pc+4.
- In ERR, redirect_valid is ignored.
- rst asserted mid-transaction: state returns to REQ and any outstanding response is ignored.
  - Memory is required to be reset with the same rst.

Test Plan:
- Reset release, memory ready=1, response one cycle later with 32'h0010_0093 -> req addr 32'h8000_0000, then inst_valid=1, inst=32'h0010_0093, pc=32'h8000_0000; with inst_ready=1 the next req addr is 32'h8000_0004 and fetch_cnt=1.
- Decode backpressure: inst_ready=0 for 5 cycles in HOLD -> inst/pc stable, no imem_req_valid; on ready, exactly one pc+4 increment.
- Redirect in WAIT to 32'h8000_0100, stale response 32'hDEAD_BEEF arrives 2 cycles later -> response dropped, inst_valid stays 0, next req addr 32'h8000_0100, fetch_cnt unchanged.
- Redirect with inst_ready in the same HOLD cycle to 32'h8000_0040 -> fetch_cnt increments, next req addr 32'h8000_0040 (not pc+4).
- Misaligned redirect 32'h8000_0002 -> fault=1, no further requests; imem_resp_err on a live response also gives fault=1; rst clears fault and restarts at 32'h8000_0000.
- PC wrap: redirect to 32'hFFFF_FFFC, deliver one instruction -> next req addr 32'h0000_0000.
